mem_write_banked: RTL and testbench

- Parametrised successor to the single-matrix A-write address generator.
- Accepts a row-major matrix stream over a valid/ready handshake and scatters each element into one of N_BANKS bank memories.
- Outputs per element: one-hot bank write-enable, in-bank address and data.
- Supports two interleave modes: row-interleaved for matrix A (feeds systolic rows) and column-interleaved for matrix B (feeds systolic columns). Adds a runtime base address, config validation and start/busy/done control. Sits between the host/DMA input stream and the bank RAMs.

---
 rtl/mem_write_banked.sv | 94 +++++++++
 tb/tb_mem_write_banked.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mem_write_banked.sv
// mem_write_banked: scatters a row-major matrix stream across N_BANKS bank memories (row- or column-interleaved).
module mem_write_banked #(
  parameter int N_BANKS      = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MATRIXSIZE_W-1:0] cfg_rows,
  input  logic [MATRIXSIZE_W-1:0] cfg_cols,
  input  logic [ADDR_W-1:0]       cfg_base,
  input  logic                    cfg_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic [N_BANKS-1:0]      wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err_cfg
);
  localparam int LB = $clog2(N_BANKS);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state;
  logic [MATRIXSIZE_W-1:0] rows, cols, row, col;
  logic [ADDR_W-1:0] row_base, step, addr;
  logic mode, bad, fire, last_col, last;
  logic [LB-1:0] bank;
  always_comb begin
    bad      = cfg_rows == '0 || cfg_cols == '0 || (cfg_mode ? |cfg_cols[LB-1:0] : |cfg_rows[LB-1:0]);
    in_ready = state == S_RUN;
    busy     = state != S_IDLE;
    fire     = in_valid && in_ready;
    last_col = col == cols - 1'b1;
    last     = last_col && row == rows - 1'b1;
    bank     = mode ? col[LB-1:0] : row[LB-1:0];
    addr     = row_base + (mode ? ADDR_W'(col >> LB) : ADDR_W'(col));
  end
  // row_base tracks base + (r/N)*C in mode 0 and base + r*(C/N) in mode 1
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rows     <= '0;
      cols     <= '0;
      row      <= '0;
      col      <= '0;
      mode     <= 1'b0;
      row_base <= '0;
      step     <= '0;
      wr_en    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      err_cfg  <= 1'b0;
    end else begin
      wr_en   <= '0;
      done    <= 1'b0;
      err_cfg <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (bad) err_cfg <= 1'b1;
          else begin
            state    <= S_RUN;
            rows     <= cfg_rows;
            cols     <= cfg_cols;
            mode     <= cfg_mode;
            row_base <= cfg_base;
            step     <= cfg_mode ? ADDR_W'(cfg_cols >> LB) : ADDR_W'(cfg_cols);
            row      <= '0;
            col      <= '0;
          end
        end
        S_RUN: if (fire) begin
          wr_en   <= N_BANKS'(1) << bank;
          wr_addr <= addr;
          wr_data <= in_data;
          col     <= last_col ? '0 : col + 1'b1;
          if (last_col) begin
            row <= row + 1'b1;
            if (mode || &row[LB-1:0]) row_base <= row_base + step;
          end
          if (last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_write_banked.sv
// tb_mem_write_banked: directed stimulus with a scoreboard of expected bank writes.
module tb_mem_write_banked;
  localparam int N = 4, MW = 16, AW = 12, DW = 32;
  logic clk = 1'b0, rst, start, cfg_mode, in_valid, in_ready, busy, done, err_cfg;
  logic [MW-1:0] cfg_rows, cfg_cols;
  logic [AW-1:0] cfg_base, wr_addr;
  logic [DW-1:0] in_data, wr_data;
  logic [N-1:0] wr_en;
  always #5 clk = ~clk;
  mem_write_banked #(.N_BANKS(N), .MATRIXSIZE_W(MW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .cfg_base(cfg_base), .cfg_mode(cfg_mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err_cfg(err_cfg));
  typedef struct packed {logic [N-1:0] en; logic [AW-1:0] addr; logic [DW-1:0] data; logic dn;} wr_t;
  wr_t sb[$];
  int passed = 0, total = 0;
  int m_state = 0, k = 0, mr = 0, mc = 1, mbase = 0, nwr = 0;
  logic mmode = 1'b0;
  int bank_cnt[N];
  logic [N-1:0] log_en[64];
  logic [AW-1:0] log_addr[64];
  logic log_done[64];
  function automatic wr_t model(int kk, logic [DW-1:0] d);
    wr_t w;
    int r, c, b, a;
    r = kk / mc;
    c = kk % mc;
    if (!mmode) begin b = r % N; a = mbase + (r / N) * mc + c; end
    else begin b = c % N; a = mbase + r * (mc / N) + c / N; end
    w.en = N'(1) << b;
    w.addr = AW'(a);
    w.data = d;
    w.dn = kk == mr * mc - 1;
    return w;
  endfunction
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic cyc();
    logic acc, bad, err_n;
    int nxt;
    wr_t e, g;
    check("in_ready", 64'(in_ready), 64'(m_state == 1));
    acc = in_valid && m_state == 1 && !rst;
    bad = cfg_rows == 0 || cfg_cols == 0 || (cfg_mode ? cfg_cols % N != 0 : cfg_rows % N != 0);
    err_n = !rst && m_state == 0 && start && bad;
    if (acc) begin sb.push_back(model(k, in_data)); k++; end
    nxt = m_state;
    if (rst) nxt = 0;
    else if (m_state == 0) begin
      if (start && !bad) begin
        nxt = 1; k = 0; mr = int'(cfg_rows); mc = int'(cfg_cols); mbase = int'(cfg_base); mmode = cfg_mode;
      end
    end else if (m_state == 1) nxt = (acc && k == mr * mc) ? 2 : 1;
    else nxt = 0;
    @(posedge clk);
    #1;
    m_state = nxt;
    check("busy", 64'(busy), 64'(m_state != 0));
    check("err_cfg", 64'(err_cfg), 64'(err_n));
    if (wr_en != 0 || acc) begin
      if (sb.size() == 0) check("unexpected_write", 64'(wr_en), 64'(0));
      else begin
        e = sb.pop_front();
        g = {wr_en, wr_addr, wr_data, done};
        check("write", 64'(g), 64'(e));
        if (nwr < 64) begin log_en[nwr] = wr_en; log_addr[nwr] = wr_addr; log_done[nwr] = done; end
        for (int b = 0; b < N; b++) if (wr_en[b]) bank_cnt[b]++;
        nwr++;
      end
    end else check("no_write", 64'({wr_en, done}), 64'(0));
    if (rst) check("rst_out", 64'({wr_en, wr_addr, wr_data, done, err_cfg, busy, in_ready}), 64'(0));
  endtask
  task automatic go(int r, int c, int base, logic mode);
    cfg_rows = MW'(r); cfg_cols = MW'(c); cfg_base = AW'(base); cfg_mode = mode;
    start = 1'b1;
    cyc();
    start = 1'b0;
    nwr = 0;
    for (int b = 0; b < N; b++) bank_cnt[b] = 0;
  endtask
  task automatic stream(int n, int gap);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = $urandom; cyc();
      in_valid = 1'b0;
      for (int j = 0; j < gap; j++) cyc();
    end
    in_valid = 1'b0;
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_rows = '0; cfg_cols = '0; cfg_base = '0; cfg_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'({wr_en, wr_addr, wr_data, done, err_cfg, busy, in_ready}), 64'(0));
    rst = 1'b0;
    idle(1);
    go(8, 3, 'h10, 1'b0);
    stream(24, 0);
    idle(2);
    check("t1_count", 64'(nwr), 64'(24));
    check("t1_b0", 64'({log_en[0], log_addr[0]}), 64'({4'b0001, 12'h010}));
    check("t1_b3", 64'({log_en[3], log_addr[3]}), 64'({4'b0010, 12'h010}));
    check("t1_b12", 64'({log_en[12], log_addr[12]}), 64'({4'b0001, 12'h013}));
    check("t1_b23", 64'({log_en[23], log_addr[23], log_done[23]}), 64'({4'b1000, 12'h015, 1'b1}));
    go(2, 8, 0, 1'b1);
    stream(16, 0);
    idle(2);
    check("t2_count", 64'(nwr), 64'(16));
    check("t2_05", 64'({log_en[5], log_addr[5]}), 64'({4'b0010, 12'h001}));
    check("t2_16", 64'({log_en[14], log_addr[14]}), 64'({4'b0100, 12'h003}));
    for (int b = 0; b < N; b++) check("t2_bank_cnt", 64'(bank_cnt[b]), 64'(4));
    go(4, 2, 0, 1'b0);
    stream(8, 2);
    idle(2);
    check("t3_count", 64'(nwr), 64'(8));
    check("t3_last", 64'({log_en[7], log_addr[7], log_done[7]}), 64'({4'b1000, 12'h001, 1'b1}));
    go(6, 4, 0, 1'b0);
    in_valid = 1'b1;
    idle(3);
    in_valid = 1'b0;
    check("t4a_count", 64'(nwr), 64'(0));
    go(4, 0, 0, 1'b0);
    idle(2);
    check("t4b_count", 64'(nwr), 64'(0));
    go(4, 4, 'h20, 1'b0);
    stream(5, 0);
    cfg_rows = 8; cfg_cols = 8; cfg_base = 'h300; cfg_mode = 1'b1; start = 1'b1;
    stream(1, 0);
    start = 1'b0;
    stream(10, 0);
    idle(2);
    check("t5_count", 64'(nwr), 64'(16));
    check("t5_b15", 64'({log_en[15], log_addr[15]}), 64'({4'b1000, 12'h023}));
    go(8, 4, 5, 1'b0);
    stream(5, 0);
    rst = 1'b1; in_valid = 1'b1;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    idle(1);
    go(8, 4, 5, 1'b0);
    stream(32, 0);
    idle(2);
    check("t6_first", 64'({log_en[0], log_addr[0]}), 64'({4'b0001, 12'h005}));
    check("t6_count", 64'(nwr), 64'(32));
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
